// File: rtl/fetch_unit.sv
// RV32 instruction fetch stage: PC, single-outstanding imem requests, small instruction FIFO.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  input  logic        PC_Src,
  input  logic [31:0] branch_target,
  output logic        misalign_err
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

  state_t            state;
  logic [31:0]       fetch_pc;
  logic [31:0]       req_pc;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [31:0]       instr_mem [FIFO_DEPTH];
  logic [31:0]       pc_mem    [FIFO_DEPTH];

  logic              pop, redirect, push, fetch_ok;
  logic [31:0]       target;
  logic [PTR_W-1:0]  rd_n, wr_n;
  logic [CNT_W-1:0]  cnt_n;
  logic              head_valid_n;
  logic [31:0]       head_instr_n, head_pc_n;

  assign pop      = instr_valid && instr_ready;
  assign redirect = pop && PC_Src;
  assign push     = (state == WAIT) && imem_rvalid && !redirect;
  assign target   = branch_target & 32'hFFFF_FFFC;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q;

  // Once a misaligned redirect is seen, fetch stops for good until reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else if (redirect && (branch_target[1:0] != 2'b00)) begin
      misalign_q <= 1'b1;
    end
  end

  assign fetch_ok     = !misalign_q;
  assign misalign_err = misalign_q;
`else
  assign fetch_ok     = 1'b1;
  assign misalign_err = 1'b0;
`endif

  // A request issued alongside a redirect would fetch the stale path, so it is held off.
  assign imem_req  = rst_n && fetch_ok && (state == IDLE) && (count < DEPTH_C) && !redirect;
  assign imem_addr = imem_req ? fetch_pc : req_pc;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  // Next FIFO state and the head entry that the output registers will show next cycle.
  always_comb begin
    rd_n         = rd_ptr;
    wr_n         = wr_ptr;
    cnt_n        = count;
    head_valid_n = 1'b0;
    head_instr_n = NOP;
    head_pc_n    = 32'h0000_0000;
    if (redirect) begin
      rd_n  = '0;
      wr_n  = '0;
      cnt_n = '0;
    end else begin
      rd_n  = rd_ptr + PTR_W'(pop);
      wr_n  = wr_ptr + PTR_W'(push);
      cnt_n = count + CNT_W'(push) - CNT_W'(pop);
    end
    if (cnt_n != '0) begin
      head_valid_n = 1'b1;
      if (push && (cnt_n == ONE_C)) begin
        head_instr_n = imem_rdata;
        head_pc_n    = req_pc;
      end else begin
        head_instr_n = instr_mem[rd_n];
        head_pc_n    = pc_mem[rd_n];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      req_pc      <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      instr_valid <= 1'b0;
      instr       <= NOP;
      instr_pc    <= 32'h0000_0000;
    end else begin
      rd_ptr      <= rd_n;
      wr_ptr      <= wr_n;
      count       <= cnt_n;
      instr_valid <= head_valid_n;
      instr       <= head_instr_n;
      instr_pc    <= head_pc_n;

      if (push) begin
        instr_mem[wr_ptr] <= imem_rdata;
        pc_mem[wr_ptr]    <= req_pc;
      end

      if (imem_req) begin
        req_pc   <= fetch_pc;
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (redirect) begin
        fetch_pc <= target;
      end

      case (state)
        IDLE: begin
          if (imem_req) state <= WAIT;
        end
        WAIT: begin
          if (redirect) begin
            state <= imem_rvalid ? IDLE : DISCARD;
          end else if (imem_rvalid) begin
            state <= IDLE;
          end
        end
        DISCARD: begin
          if (imem_rvalid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
